led_pwm_ctrl: RTL
=================

LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, giving the LED channel count (1..32).
REQ-002 SHALL have parameter PWM_BITS, default 8, giving the duty/PWM counter width (1..16).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0300_0000, giving the register window base (256-byte aligned).
REQ-004 SHALL have parameter BLINK_DIV, default 64, giving the PWM periods per blink phase (used only with LED_BLINK_EN).
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, the reset (synchronous, active-high).
REQ-007 SHALL have port mem_valid, input, 1, CPU native-bus request.
REQ-008 SHALL have port mem_addr, input, 32, byte address.
REQ-009 SHALL have port mem_wdata, input, 32, write data.
REQ-010 SHALL have port mem_wstrb, input, 4, byte write strobes (0 = read).
REQ-011 SHALL have port mem_ready, output, 1, transfer acknowledge.
REQ-012 SHALL have port mem_rdata, output, 32, read data.
REQ-013 SHALL have port led, output, NUM_LEDS, registered LED drive (1 = lit).

Function
REQ-014 SHALL select when mem_valid=1 and mem_addr[31:8]==BASE_ADDR[31:8]; unselected requests get no mem_ready.
REQ-015 SHALL pulse mem_ready for exactly one cycle, one cycle after a selected request; no acknowledge in the cycle following one (no double-ack).
REQ-016 SHALL implement OUT at 0x00 (direct LED bits), MODE at 0x04 (1 = PWM), PRESC at 0x08 (16 bits), BLINK at 0x0C, and DUTY[i] at 0x10+4*i (PWM_BITS bits).
REQ-017 SHALL honour mem_wstrb per byte; unused bits SHALL read 0; reads of unmapped offsets SHALL return 0 and still be acknowledged.
REQ-018 SHALL run a prescaler counting 0..PRESC, emitting a tick on PRESC and then wrapping to 0; PRESC=0 ticks every cycle.
REQ-019 SHALL advance pwm_cnt by 1 per tick, wrapping 2^PWM_BITS-1 -> 0.
REQ-020 SHALL compute led[i] one cycle after its inputs: MODE[i]=0 -> OUT[i]; MODE[i]=1 -> (pwm_cnt < DUTY[i]); so DUTY=0 is never lit and the maximum duty is lit 2^PWM_BITS-1 of 2^PWM_BITS steps.
REQ-021 SHALL restart the prescaler at 0 when PRESC is written, without altering pwm_cnt.
REQ-022 SHALL let a write and the tick in the same cycle both take effect, with the new register value used from the next cycle.

Reset
REQ-023 SHALL, with rst high at a clk edge, clear OUT, MODE, PRESC, BLINK, all DUTY, the counters, blink phase, led and mem_ready to 0.
REQ-024 SHALL abandon a request pending during reset, returning no mem_ready for it.

Configuration
REQ-025 SHALL, with LED_BLINK_EN defined, use BLINK[NUM_LEDS-1:0] as a mask; a phase bit toggles every BLINK_DIV pwm_cnt wraps, and masked LEDs SHALL be forced off while the phase is 0.
REQ-026 SHALL, with LED_BLINK_EN undefined, read BLINK as 0, ignore writes to it, and include no blink logic.

Structure
REQ-027 SHALL place the register offset constants and the BLINK_DIV default in a shared package, led_pwm_pkg.
REQ-028 SHALL factor the prescaler plus pwm_cnt into one sub-module, led_pwm_timebase.

Verification
REQ-029 SHALL check: reset, then write OUT=8'hA5 -> mem_ready 1 cycle later; led=8'hA5 on the following cycle.
REQ-030 SHALL check: PRESC=0, MODE=8'h01, DUTY[0]=64 -> led[0] high for exactly 64 of every 256 cycles.
REQ-031 SHALL check: DUTY[1]=0 and DUTY[2]=255 in PWM mode -> led[1] is never high; led[2] is low for exactly 1 of 256 cycles.
REQ-032 SHALL check: write wstrb=4'b0001 with wdata=32'hFFFF_FF3C to OUT holding 8'h00 -> readback is 32'h0000_003C.
REQ-033 SHALL check: read offset 0x80 -> mem_rdata=0 and mem_ready asserted; an address outside the window gets no mem_ready within 10 cycles.
REQ-034 SHALL check: with LED_BLINK_EN, BLINK=8'h01, OUT=8'h01, PRESC=0 -> led[0] alternates every 64*256 cycles; rst asserted mid-run clears led on the next edge.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared constants and helpers for the LED PWM controller.
// Register offsets are byte offsets inside the 256-byte window.
package led_pwm_pkg;

  localparam int         BLINK_DIV_DEFAULT = 64;

  localparam logic [7:0] OFF_OUT   = 8'h00;
  localparam logic [7:0] OFF_MODE  = 8'h04;
  localparam logic [7:0] OFF_PRESC = 8'h08;
  localparam logic [7:0] OFF_BLINK = 8'h0C;
  localparam logic [7:0] OFF_DUTY0 = 8'h10;

  // Merge write data into the current register image, byte by byte.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler (0..presc, tick on presc) driving the shared PWM step counter.
// A write to the prescale register restarts the prescaler but keeps pwm_cnt.
module led_pwm_timebase #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         presc,
  input  logic                presc_wr,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm_wrap
);

  logic [15:0]         presc_cnt_q, presc_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                tick;

  always_comb begin
    tick        = (presc_cnt_q == presc);
    presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
    if (presc_wr) presc_cnt_d = 16'd0;
    pwm_cnt_d   = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    pwm_wrap    = tick && (&pwm_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED controller: direct drive or per-channel PWM.
// Optional blink masking is built only when LED_BLINK_EN is defined.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int          NUM_LEDS  = 8,
  parameter int          PWM_BITS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int          BLINK_DIV = BLINK_DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  output logic                mem_ready,
  output logic [31:0]         mem_rdata,
  output logic [NUM_LEDS-1:0] led
);

  logic                ready_q, ready_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NUM_LEDS-1:0] out_q, out_d, mode_q, mode_d, led_q, led_d;
  logic [15:0]         presc_q, presc_d;
  logic [PWM_BITS-1:0] duty_q [NUM_LEDS];
  logic [PWM_BITS-1:0] duty_d [NUM_LEDS];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_wrap;
  logic                sel, ack, wr, presc_wr;
  logic [7:0]          off;
  logic [31:0]         rd_val, wr_val;

  led_pwm_timebase #(.PWM_BITS(PWM_BITS)) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .presc    (presc_q),
    .presc_wr (presc_wr),
    .pwm_cnt  (pwm_cnt),
    .pwm_wrap (pwm_wrap)
  );

`ifdef LED_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [NUM_LEDS-1:0] blink_q, blink_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
`endif

  always_comb begin
    // Ack only the first cycle of a held request, so a CPU that keeps
    // mem_valid high for the ack cycle never sees a second pulse.
    sel     = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
    ack     = sel && !ready_q;
    wr      = ack && (mem_wstrb != 4'b0000);
    off     = mem_addr[7:0];
    ready_d = ack;

    rd_val = '0;
    case (off)
      OFF_OUT:   rd_val[NUM_LEDS-1:0] = out_q;
      OFF_MODE:  rd_val[NUM_LEDS-1:0] = mode_q;
      OFF_PRESC: rd_val[15:0]         = presc_q;
`ifdef LED_BLINK_EN
      OFF_BLINK: rd_val[NUM_LEDS-1:0] = blink_q;
`endif
      default:   rd_val = '0;
    endcase
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (off == OFF_DUTY0 + 8'(4 * i)) rd_val[PWM_BITS-1:0] = duty_q[i];
    end

    wr_val   = apply_wstrb(rd_val, mem_wdata, mem_wstrb);
    out_d    = out_q;
    mode_d   = mode_q;
    presc_d  = presc_q;
    presc_wr = 1'b0;
    duty_d   = duty_q;
`ifdef LED_BLINK_EN
    blink_d  = blink_q;
`endif
    if (wr) begin
      case (off)
        OFF_OUT:   out_d  = wr_val[NUM_LEDS-1:0];
        OFF_MODE:  mode_d = wr_val[NUM_LEDS-1:0];
        OFF_PRESC: begin
          presc_d  = wr_val[15:0];
          presc_wr = 1'b1;
        end
`ifdef LED_BLINK_EN
        OFF_BLINK: blink_d = wr_val[NUM_LEDS-1:0];
`endif
        default: ;
      endcase
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (off == OFF_DUTY0 + 8'(4 * i)) duty_d[i] = wr_val[PWM_BITS-1:0];
      end
    end
    rdata_d = (ack && !wr) ? rd_val : 32'h0;

`ifdef LED_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (pwm_wrap) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        phase_d     = !phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
`endif

    for (int i = 0; i < NUM_LEDS; i++) begin
      led_d[i] = mode_q[i] ? (pwm_cnt < duty_q[i]) : out_q[i];
`ifdef LED_BLINK_EN
      if (blink_q[i] && !phase_q) led_d[i] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      out_q   <= '0;
      mode_q  <= '0;
      presc_q <= '0;
      duty_q  <= '{default: '0};
      led_q   <= '0;
`ifdef LED_BLINK_EN
      blink_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
`endif
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      duty_q  <= duty_d;
      led_q   <= led_d;
`ifdef LED_BLINK_EN
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
`endif
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign led       = led_q;

endmodule
